link_hang_monitor: RTL and testbench
====================================

// Module: link_hang_monitor
// PURPOSE
//   Passive, zero-latency tap on one inter-router link, placed directly downstream of the
//   link fault injector and upstream of the receiving router input port. Forwards all link
//   signals unchanged, tracks packet framing, measures intra-packet stall cycles, flags hangs
//   and framing errors, and exposes saturating statistics for the testbench and debug logic.
// PARAMETERS
//   ADDRESS      16'h0000  router address owning the link; [15:8]=X, [7:0]=Y; debug only
//   STALL_LIMIT  64        stall cycles inside a packet that constitute a hang; range 1..65535
//   CNT_W        16        width of every statistics counter
// PORTS
//   clk_i        in   1      clock
//   rst_ni       in   1      reset, asynchronous, active-low
//   tx_i         in   1      flit valid from upstream (fault injector output)
//   eop_tx_i     in   1      current flit is the last of its packet
//   data_tx_i    in   32     flit data
//   cr_tx_o      out  1      credit to upstream; equals cr_rx_i
//   rx_o         out  1      flit valid to receiver; equals tx_i
//   eop_rx_o     out  1      equals eop_tx_i
//   data_rx_o    out  32     equals data_tx_i
//   cr_rx_i      in   1      credit from receiver
//   clear_i      in   1      synchronous clear of statistics and err_o
//   hang_o       out  1      a stall of STALL_LIMIT or more cycles is currently in progress
//   err_o        out  1      sticky framing error
//   pkt_cnt_o    out  CNT_W  packets completed (EOP accepted), saturating
//   hang_cnt_o   out  CNT_W  hang episodes detected, saturating
//   max_stall_o  out  16     longest stall observed (cycles), updated when the stall ends
// BEHAVIOUR
// - Transfer: xfer = tx_i & cr_rx_i. Data path is purely combinational; the block never
//   modifies, delays or blocks a flit.
// - Packet format: flit0 = header, flit1 = size N (data_tx_i[15:0]), then N payload flits.
//   Last flit carries eop. N==0 means the size flit carries eop.
// - FSM (registered, reset IDLE):
//   IDLE:    xfer -> SIZE. A header flit with eop -> err_o set, stay IDLE.
//   SIZE:    xfer: latch rem=N. N==0 & eop -> IDLE (packet done). N==0 & !eop -> DRAIN with
//            err. N>0 & eop -> IDLE with err. Otherwise -> PAYLOAD.
//   PAYLOAD: on xfer rem decrements. rem==1 & eop -> IDLE (done). rem==1 & !eop -> DRAIN with
//            err. rem>1 & eop -> IDLE with err.
//   DRAIN:   xfer & eop -> IDLE. No other exit; no packet counted.
// - "Packet done" increments pkt_cnt_o. An erroneous EOP does not count.
// - Stall counter stall (16b, saturating at 16'hFFFF): cleared on xfer. Increments every
//   cycle without xfer while state is SIZE, PAYLOAD or DRAIN. Held at 0 in IDLE, so
//   inter-packet idle time never counts as a stall.
// - Hang: when stall becomes STALL_LIMIT (increment landing exactly on it), hang_o rises in
//   that same registered update and hang_cnt_o increments once. hang_o stays high until the
//   next xfer, then clears in the following cycle. One episode counts once, regardless of
//   its length.
// - Stall end: on xfer, if stall > max_stall_o then max_stall_o <= stall.
// - Counter saturation: all counters hold at all-ones; they never wrap.
// - clear_i: next cycle pkt_cnt_o, hang_cnt_o, max_stall_o and err_o are 0. clear_i wins
//   over a same-cycle increment or error; that event is lost. clear_i does not affect the
//   FSM, stall or hang_o.
// - Reset: FSM IDLE; stall, rem and all counters 0; hang_o=0, err_o=0. Forwarded outputs
//   follow their inputs even during reset. Reset asserted mid-packet abandons the packet;
//   after release, the next flit is treated as a header.
// - Simultaneous xfer and STALL_LIMIT cannot both occur, because xfer clears stall first.
// TESTING
// 1. Header, size=3, 3 payload flits (last eop), cr_rx_i held 1 -> pkt_cnt_o=1, err_o=0,
//    hang_o=0, max_stall_o=0, outputs identical to inputs each cycle.
// 2. STALL_LIMIT=64: after the size flit, drop cr_rx_i for 100 cycles, then resume ->
//    hang_o rises 64 cycles after the stall begins, hang_cnt_o=1, hang_o falls 1 cycle after
//    resume, max_stall_o=100.
// 3. size=2 but eop on the 1st payload flit -> err_o=1, pkt_cnt_o unchanged, FSM IDLE; next
//    well-formed packet counted.
// 4. size=1, payload without eop, 2 extra flits, last with eop -> err_o=1, DRAIN exits on
//    that eop, pkt_cnt_o=0.
// 5. 1000 idle cycles between packets -> stall stays 0, hang_cnt_o=0; clear_i on the same
//    cycle as an eop -> all statistics 0 afterwards.
// 6. Assert rst_ni low mid-payload -> all outputs reset. The following packet is parsed
//    correctly: pkt_cnt_o=1.

Source files
------------

// File: rtl/link_hang_monitor.sv
// link_hang_monitor: passive tap on one inter-router link; forwards flits, checks framing, measures stalls.
// Latency: zero on the forwarded link signals; flags and statistics update on the clock edge after the event.
// Backpressure: none applied; credits pass straight through and the tap never blocks or delays a flit.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   tx_i/eop_tx_i/data_tx_i/cr_tx_o   upstream side (from the fault injector)
//   rx_o/eop_rx_o/data_rx_o/cr_rx_i   downstream side (to the receiving router)
//   clear_i                           synchronous clear of statistics and err_o
//   hang_o, err_o                     stall-beyond-limit in progress, sticky framing error
//   pkt_cnt_o, hang_cnt_o             saturating packet and hang-episode counters
//   max_stall_o                       longest completed stall in cycles
module link_hang_monitor #(
    parameter logic [15:0] ADDRESS     = 16'h0000,  // link owner, [15:8]=X [7:0]=Y; debug only
    parameter int unsigned STALL_LIMIT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tx_i,
    input  logic             eop_tx_i,
    input  logic [31:0]      data_tx_i,
    output logic             cr_tx_o,
    output logic             rx_o,
    output logic             eop_rx_o,
    output logic [31:0]      data_rx_o,
    input  logic             cr_rx_i,
    input  logic             clear_i,
    output logic             hang_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] hang_cnt_o,
    output logic [15:0]      max_stall_o
);

    // The stall counter is 16 bits wide, so the limit must fit in it.
    if (STALL_LIMIT < 1 || STALL_LIMIT > 65535) begin : g_bad_limit
        $error("link_hang_monitor %h: STALL_LIMIT out of range", ADDRESS);
    end

    typedef enum logic [1:0] {IDLE, SIZE, PAYLOAD, DRAIN} state_t;

    // A hang is declared when an increment lands exactly on STALL_LIMIT.
    localparam logic [15:0]      HANG_AT = 16'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state;
    logic [15:0] rem;
    logic [15:0] stall;

    logic xfer;
    logic last;
    logic pkt_done;
    logic frame_err;
    logic stall_inc;
    logic hang_rise;

    // Pure pass-through of the link.
    assign rx_o      = tx_i;
    assign eop_rx_o  = eop_tx_i;
    assign data_rx_o = data_tx_i;
    assign cr_tx_o   = cr_rx_i;

    assign xfer = tx_i & cr_rx_i;

    // "last" is true when the flit being offered should carry eop: a size flit announcing
    // zero payload, or the final payload flit. Any disagreement with eop is a framing error.
    always_comb begin
        last      = 1'b0;
        pkt_done  = 1'b0;
        frame_err = 1'b0;
        case (state)
            SIZE:    last = (data_tx_i[15:0] == 16'd0);
            PAYLOAD: last = (rem == 16'd1);
            default: last = 1'b0;
        endcase
        if (xfer) begin
            if (state == IDLE) begin
                frame_err = eop_tx_i;
            end else if (state != DRAIN) begin
                pkt_done  = last & eop_tx_i;
                frame_err = last ^ eop_tx_i;
            end
        end
    end

    assign stall_inc = !xfer && (state != IDLE) && (stall != 16'hFFFF);
    assign hang_rise = stall_inc && (stall == HANG_AT);

    // Packet framing FSM; only advances on accepted flits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            rem   <= 16'd0;
        end else if (xfer) begin
            case (state)
                IDLE: begin
                    // A header carrying eop is a one-flit frame: error, stay idle.
                    if (!eop_tx_i) state <= SIZE;
                end
                SIZE, PAYLOAD: begin
                    rem <= (state == SIZE) ? data_tx_i[15:0] : rem - 16'd1;
                    if (eop_tx_i)  state <= IDLE;
                    else if (last) state <= DRAIN;
                    else           state <= PAYLOAD;
                end
                DRAIN: begin
                    if (eop_tx_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall measurement and hang flag; unaffected by clear_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall  <= 16'd0;
            hang_o <= 1'b0;
        end else begin
            if (xfer || state == IDLE) stall <= 16'd0;
            else if (stall_inc)        stall <= stall + 16'd1;

            if (xfer)           hang_o <= 1'b0;
            else if (hang_rise) hang_o <= 1'b1;
        end
    end

    // Statistics; clear_i takes priority and drops any same-cycle event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_o   <= '0;
            hang_cnt_o  <= '0;
            max_stall_o <= 16'd0;
            err_o       <= 1'b0;
        end else if (clear_i) begin
            pkt_cnt_o   <= '0;
            hang_cnt_o  <= '0;
            max_stall_o <= 16'd0;
            err_o       <= 1'b0;
        end else begin
            if (pkt_done && pkt_cnt_o != CNT_MAX)   pkt_cnt_o  <= pkt_cnt_o + 1'b1;
            if (hang_rise && hang_cnt_o != CNT_MAX) hang_cnt_o <= hang_cnt_o + 1'b1;
            if (xfer && stall > max_stall_o)        max_stall_o <= stall;
            if (frame_err)                          err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_link_hang_monitor.sv
// tb_link_hang_monitor: vector table plus hand sequences for stall, drain, clear and reset.
// Latency: expectations are checked one cycle after each driven flit (forwarding checked combinationally).
// Backpressure: cr_rx_i is driven by the bench to create stalls.
module tb_link_hang_monitor;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tx_i = 1'b0;
    logic        eop_tx_i = 1'b0;
    logic [31:0] data_tx_i = 32'd0;
    logic        cr_tx_o;
    logic        rx_o;
    logic        eop_rx_o;
    logic [31:0] data_rx_o;
    logic        cr_rx_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        hang_o;
    logic        err_o;
    logic [15:0] pkt_cnt_o;
    logic [15:0] hang_cnt_o;
    logic [15:0] max_stall_o;

    int total = 0;
    int bad   = 0;

    link_hang_monitor #(
        .ADDRESS(16'h0102),
        .STALL_LIMIT(64),
        .CNT_W(16)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .tx_i(tx_i),
        .eop_tx_i(eop_tx_i),
        .data_tx_i(data_tx_i),
        .cr_tx_o(cr_tx_o),
        .rx_o(rx_o),
        .eop_rx_o(eop_rx_o),
        .data_rx_o(data_rx_o),
        .cr_rx_i(cr_rx_i),
        .clear_i(clear_i),
        .hang_o(hang_o),
        .err_o(err_o),
        .pkt_cnt_o(pkt_cnt_o),
        .hang_cnt_o(hang_cnt_o),
        .max_stall_o(max_stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        tx, eop, cr, clr;
        logic [31:0] data;
        logic [15:0] pkt, hcnt, ms;
        logic        err, hang;
    } vec_t;

    typedef struct {
        string       tag;
        logic [15:0] pkt, hcnt, ms;
        logic        err, hang;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[16];

    function automatic vec_t mk(input logic tx, eop, cr, clr, input logic [31:0] data,
                                input logic [15:0] pkt, hcnt, ms, input logic err, hang);
        vec_t v;
        v.tx = tx; v.eop = eop; v.cr = cr; v.clr = clr; v.data = data;
        v.pkt = pkt; v.hcnt = hcnt; v.ms = ms; v.err = err; v.hang = hang;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] pkt, hcnt, ms,
                           input logic err, hang);
        exp_t e;
        e.tag = tag; e.pkt = pkt; e.hcnt = hcnt; e.ms = ms; e.err = err; e.hang = hang;
        exp_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        cmp({e.tag, ".pkt_cnt"},   64'(pkt_cnt_o),   64'(e.pkt));
        cmp({e.tag, ".hang_cnt"},  64'(hang_cnt_o),  64'(e.hcnt));
        cmp({e.tag, ".max_stall"}, 64'(max_stall_o), 64'(e.ms));
        cmp({e.tag, ".err"},       64'(err_o),       64'(e.err));
        cmp({e.tag, ".hang"},      64'(hang_o),      64'(e.hang));
    endtask

    // Drive one cycle of link stimulus, check the pass-through, then step past the edge.
    task automatic drive(input logic tx, eop, input logic [31:0] d, input logic cr, clr);
        tx_i = tx; eop_tx_i = eop; data_tx_i = d; cr_rx_i = cr; clear_i = clr;
        #1;
        cmp("fwd", 64'({rx_o, eop_rx_o, data_rx_o, cr_tx_o}), 64'({tx, eop, d, cr}));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE_0001, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h5A5A_0003, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0011, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0022, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0033, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE_0002, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 16'd1, 16'd0, 16'd0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE_0003, 16'd1, 16'd0, 16'd0, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 16'd1, 16'd0, 16'd0, 1'b1, 1'b0);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 16'd1, 16'd0, 16'd0, 1'b1, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0055, 16'd2, 16'd0, 16'd1, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'hC0DE_0004, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        vecs[15] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'hC0DE_0005, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);

        // Reset state, with forwarding active during reset.
        tx_i = 1'b1; eop_tx_i = 1'b1; data_tx_i = 32'hDEAD_BEEF; cr_rx_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        cmp("fwd_in_reset", 64'({rx_o, eop_rx_o, data_rx_o, cr_tx_o}), 64'({1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1}));
        sb_push("reset", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        sb_check();
        tx_i = 1'b0; eop_tx_i = 1'b0; data_tx_i = 32'd0; cr_rx_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Table: well-formed packet, early eop, credit-stalled flit, clear, header with eop.
        for (int i = 0; i < 16; i++) begin
            sb_push($sformatf("vec%0d", i), vecs[i].pkt, vecs[i].hcnt, vecs[i].ms,
                    vecs[i].err, vecs[i].hang);
            drive(vecs[i].tx, vecs[i].eop, vecs[i].data, vecs[i].cr, vecs[i].clr);
            sb_check();
        end

        // Hang: 100-cycle credit stall after the size flit.
        drive(1'b1, 1'b0, 32'hC0DE_0010, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            sb_push($sformatf("stall%0d", i), 16'd0, (i >= 64) ? 16'd1 : 16'd0, 16'd0,
                    1'b0, (i >= 64));
            drive(1'b1, 1'b1, 32'h0000_00AA, 1'b0, 1'b0);
            sb_check();
        end
        sb_push("resume", 16'd1, 16'd1, 16'd100, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_00AA, 1'b1, 1'b0);
        sb_check();

        // Missing eop on the last payload flit: drain until eop, nothing counted.
        drive(1'b1, 1'b0, 32'hC0DE_0020, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        sb_push("drain_in", 16'd1, 16'd1, 16'd100, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_00BB, 1'b1, 1'b0);
        sb_check();
        for (int i = 0; i < 3; i++) begin
            sb_push($sformatf("drain%0d", i), 16'd1, 16'd1, 16'd100, 1'b1, 1'b0);
            drive(1'b1, (i == 2), 32'h0000_0000, 1'b1, 1'b0);
            sb_check();
        end
        drive(1'b1, 1'b0, 32'hC0DE_0021, 1'b1, 1'b0);
        sb_push("after_drain", 16'd2, 16'd1, 16'd100, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        sb_check();

        // Long idle between packets must not count as a stall.
        sb_push("clear", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        sb_check();
        drive(1'b1, 1'b0, 32'hC0DE_0030, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        repeat (1000) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        sb_push("idle_end", 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'hC0DE_0031, 1'b1, 1'b0);
        sb_check();
        drive(1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        sb_push("clr_on_eop", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_00CC, 1'b1, 1'b1);
        sb_check();
        drive(1'b1, 1'b0, 32'hC0DE_0032, 1'b1, 1'b0);
        sb_push("post_clear_pkt", 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        sb_check();

        // Reset mid-payload while hung, then a fresh packet.
        drive(1'b1, 1'b1, 32'hC0DE_0040, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'hC0DE_0041, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0003, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_00DD, 1'b1, 1'b0);
        repeat (70) drive(1'b1, 1'b0, 32'h0000_00EE, 1'b0, 1'b0);
        sb_push("pre_reset", 16'd1, 16'd1, 16'd0, 1'b1, 1'b1);
        sb_check();
        rst_ni = 1'b0;
        #2;
        sb_push("mid_reset", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        sb_check();
        cmp("fwd_mid_reset", 64'({rx_o, eop_rx_o, data_rx_o, cr_tx_o}), 64'({1'b1, 1'b0, 32'h0000_00EE, 1'b0}));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive(1'b1, 1'b0, 32'hC0DE_0050, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        sb_push("after_reset_pkt", 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
        sb_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
